// File: rtl/mod2011_pkg.sv
// Shared constants and types for the mod-2011 residue datapath.
// Holds the modulus, residue/counter widths, operand chunking constants,
// the residue type and the accumulator state enum.
package mod2011_pkg;

    localparam int unsigned MODULUS  = 2011;  // 2^10 < MODULUS < 2^11
    localparam int unsigned W        = 11;    // residue width, z00 = LSB
    localparam int unsigned CNT_W    = 7;     // term counter, saturates at 127
    localparam int unsigned N_CHUNKS = 84;    // six-bit chunks in a 500-bit operand
    localparam int unsigned CHUNK_W  = 6;     // LUT input width

    typedef logic [W-1:0] residue_t;

    typedef enum logic {
        S_ACC = 1'b0,
        S_OUT = 1'b1
    } state_t;

endpackage

// File: rtl/mod2011_add_reduce.sv
// Combinational modular adder: sum_c = (a + b) mod MODULUS.
// Both operands must already be below MODULUS, so one conditional
// subtract of the W+1-bit sum is enough.
// Ports:
//   a, b   in   W   addends, each < MODULUS
//   sum_c  out  W   reduced sum, always < MODULUS
module mod2011_add_reduce
    import mod2011_pkg::*;
(
    input  residue_t a,
    input  residue_t b,
    output residue_t sum_c
);

    localparam logic [W:0] MOD_X = (W+1)'(MODULUS);

    logic [W:0] sum_wide;

    always_comb begin
        sum_wide = {1'b0, a} + {1'b0, b};
        if (sum_wide >= MOD_X) begin
            sum_c = W'(sum_wide - MOD_X);
        end else begin
            sum_c = W'(sum_wide);
        end
    end

endmodule

// File: rtl/mod2011_serial_accumulator.sv
// Serial mod-2011 accumulator: takes one LUT residue per handshake, keeps a
// running sum mod MODULUS and presents the final residue and term count after
// the term flagged in_last. One bubble cycle (S_OUT) per operand.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   in_valid      in_residue/in_last valid
//   in_ready      accumulator can take a term (S_ACC)
//   in_residue    W-bit term, nominally < MODULUS
//   in_last       final term of the current operand
//   out_valid     out_residue/out_terms valid (S_OUT)
//   out_ready     downstream accepts the result
//   out_residue   final sum mod MODULUS, held after S_OUT exits
//   out_terms     terms accepted for the operand, saturating
//   err_range     sticky flag: an accepted term was >= MODULUS
module mod2011_serial_accumulator
    import mod2011_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_residue,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_residue,
    output logic [CNT_W-1:0] out_terms,
    output logic             err_range
);

    localparam residue_t MOD_R = W'(MODULUS);

    state_t             state;
    residue_t           acc;
    logic [CNT_W-1:0]   cnt;

    logic               accept_c;
    logic               range_err_c;
    residue_t           term_c;
    residue_t           sum_c;
    logic [CNT_W-1:0]   cnt_next_c;

    // Handshake outputs decode straight from the state register.
    assign in_ready  = (state == S_ACC);
    assign out_valid = (state == S_OUT);
    assign accept_c  = in_valid & in_ready;

    // Out-of-range terms are folded back once; valid since in_residue < 2*MODULUS.
    always_comb begin
        range_err_c = (in_residue >= MOD_R);
        term_c      = range_err_c ? residue_t'(in_residue - MOD_R) : in_residue;
        cnt_next_c  = (cnt == '1) ? cnt : cnt + CNT_W'(1);
    end

    mod2011_add_reduce u_add_reduce (
        .a     (acc),
        .b     (term_c),
        .sum_c (sum_c)
    );

    // FSM, accumulator, counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_ACC;
            acc         <= '0;
            cnt         <= '0;
            out_residue <= '0;
            out_terms   <= '0;
            err_range   <= 1'b0;
        end else begin
            case (state)
                S_ACC: begin
                    if (accept_c) begin
                        if (range_err_c) begin
                            err_range <= 1'b1;
                        end
                        if (in_last) begin
                            out_residue <= sum_c;
                            out_terms   <= cnt_next_c;
                            acc         <= '0;
                            cnt         <= '0;
                            state       <= S_OUT;
                        end else begin
                            acc <= sum_c;
                            cnt <= cnt_next_c;
                        end
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        state <= S_ACC;
                    end
                end
                default: state <= S_ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_mod2011_serial_accumulator.sv
// Self-checking bench for mod2011_serial_accumulator: directed cases with
// hand-computed constants plus randomized valid/ready/reset traffic checked
// every cycle against a queue-based reference of (sum of terms) mod 2011.
module tb_mod2011_serial_accumulator;

    localparam int unsigned M       = 2011;
    localparam int unsigned SAT_MAX = 127;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] in_residue;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] out_residue;
    logic [6:0]  out_terms;
    logic        err_range;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    mod2011_serial_accumulator dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_residue  (in_residue),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_residue (out_residue),
        .out_terms   (out_terms),
        .err_range   (err_range)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: terms of the open operand in a queue; the result is the
    // plain arithmetic sum of those terms mod 2011 and a saturated term count.
    initial begin : ref_model
        int unsigned cur_terms[$];
        bit          live;
        bit          m_pending;
        bit          m_err;
        int unsigned m_res;
        int unsigned m_terms;
        int unsigned total;
        live      = 1'b0;
        m_pending = 1'b0;
        m_err     = 1'b0;
        m_res     = 0;
        m_terms   = 0;
        forever begin
            @(negedge clk);
            if (live) begin
                check_eq("m_out_valid", 32'(out_valid), 32'(m_pending));
                check_eq("m_in_ready", 32'(in_ready), 32'(!m_pending));
                check_eq("m_out_residue", 32'(out_residue), m_res);
                check_eq("m_out_terms", 32'(out_terms), m_terms);
                check_eq("m_err_range", 32'(err_range), 32'(m_err));
            end
            if (rst) begin
                cur_terms.delete();
                m_pending = 1'b0;
                m_err     = 1'b0;
                m_res     = 0;
                m_terms   = 0;
                live      = 1'b1;
            end else if (live) begin
                if (m_pending) begin
                    if (out_ready) m_pending = 1'b0;
                end else if (in_valid) begin
                    cur_terms.push_back(32'(in_residue));
                    if (32'(in_residue) >= M) m_err = 1'b1;
                    if (in_last) begin
                        total = 0;
                        foreach (cur_terms[i]) total = total + cur_terms[i];
                        m_res     = total % M;
                        m_terms   = (cur_terms.size() > SAT_MAX) ? SAT_MAX : cur_terms.size();
                        m_pending = 1'b1;
                        cur_terms.delete();
                    end
                end
            end
        end
    end

    // Present one term and hold it until accepted (bounded).
    task automatic send_term(input int unsigned t, input bit last);
        int guard;
        guard      = 0;
        in_valid   = 1'b1;
        in_residue = 11'(t);
        in_last    = last;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard = guard + 1;
        end
        check_eq("send_timeout", 32'(guard < 50), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Wait (bounded) for a result, capture it and complete the handshake.
    task automatic get_result(output int unsigned res, output int unsigned terms);
        int guard;
        guard     = 0;
        out_ready = 1'b1;
        while (!out_valid && guard < 50) begin
            @(posedge clk); #1;
            guard = guard + 1;
        end
        check_eq("result_timeout", 32'(guard < 50), 32'd1);
        res   = 32'(out_residue);
        terms = 32'(out_terms);
        @(posedge clk); #1;
    endtask

    initial begin : main
        int unsigned res;
        int unsigned terms;
        int          start;
        bit          accepted;

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_residue = '0;
        in_last    = 1'b0;
        out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_residue", 32'(out_residue), 32'd0);
        check_eq("rst_out_terms", 32'(out_terms), 32'd0);
        check_eq("rst_err_range", 32'(err_range), 32'd0);
        rst = 1'b0;

        // Exact wrap to zero, then MODULUS-1 + MODULUS-1.
        send_term(1000, 1'b0);
        send_term(1011, 1'b1);
        check_eq("wrap_latency", 32'(out_valid), 32'd1);
        get_result(res, terms);
        check_eq("wrap_residue", res, 32'd0);
        check_eq("wrap_terms", terms, 32'd2);
        send_term(2010, 1'b0);
        send_term(2010, 1'b1);
        get_result(res, terms);
        check_eq("max_residue", res, 32'd2009);
        check_eq("max_terms", terms, 32'd2);

        // Full 84-chunk operand, one term per cycle.
        start = cyc;
        for (int i = 0; i < 84; i++) send_term(2010, i == 83);
        check_eq("thru_cycles", 32'(cyc - start), 32'd84);
        check_eq("thru_valid", 32'(out_valid), 32'd1);
        get_result(res, terms);
        check_eq("op84_residue", res, 32'd1927);
        check_eq("op84_terms", terms, 32'd84);

        // Out-of-range single term.
        send_term(2047, 1'b1);
        get_result(res, terms);
        check_eq("range_residue", res, 32'd36);
        check_eq("range_terms", terms, 32'd1);
        check_eq("range_err", 32'(err_range), 32'd1);

        // Backpressure: result held while the next term waits.
        out_ready = 1'b0;
        send_term(300, 1'b0);
        send_term(400, 1'b1);
        in_valid   = 1'b1;
        in_residue = 11'd5;
        in_last    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_eq("bp_in_ready", 32'(in_ready), 32'd0);
            check_eq("bp_out_valid", 32'(out_valid), 32'd1);
            check_eq("bp_residue", 32'(out_residue), 32'd700);
            check_eq("bp_terms", 32'(out_terms), 32'd2);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("bp_release_ready", 32'(in_ready), 32'd1);
        check_eq("bp_release_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_eq("bp_held_valid", 32'(out_valid), 32'd1);
        check_eq("bp_held_residue", 32'(out_residue), 32'd5);
        check_eq("bp_held_terms", 32'(out_terms), 32'd1);
        check_eq("err_sticky", 32'(err_range), 32'd1);
        @(posedge clk); #1;
        check_eq("retain_residue", 32'(out_residue), 32'd5);

        // Reset mid-operand discards the partial sum and clears err_range.
        send_term(500, 1'b0);
        send_term(600, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("midrst_err", 32'(err_range), 32'd0);
        check_eq("midrst_terms", 32'(out_terms), 32'd0);
        send_term(7, 1'b1);
        get_result(res, terms);
        check_eq("midrst_residue", res, 32'd7);
        check_eq("midrst_count", terms, 32'd1);

        // Counter saturation: 130 terms report 127.
        for (int i = 0; i < 130; i++) send_term(2010, i == 129);
        get_result(res, terms);
        check_eq("sat_residue", res, 32'd1881);
        check_eq("sat_terms", terms, 32'd127);

        // Randomized traffic; the reference model checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            accepted = in_valid && in_ready && !rst;
            @(posedge clk); #1;
            rst = ($urandom_range(0, 399) == 0);
            if (!in_valid || accepted) begin
                in_valid   = ($urandom_range(0, 3) != 0);
                in_residue = ($urandom_range(0, 19) == 0) ? 11'($urandom_range(2011, 2047))
                                                          : 11'($urandom_range(0, 2010));
                in_last    = ($urandom_range(0, 9) == 0);
            end
            out_ready = ($urandom_range(0, 2) != 0);
        end

        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
